bcd_time_counter: RTL and testbench

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

---
 rtl/bcd_time_counter.sv | 209 ++++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// -----------------------------------------------------------------------------
// bcd_time_counter
//   Real-time clock that keeps the time of day as 24-hour BCD hh:mm:ss. A
//   prescaler turns TICK_DIV clk cycles into one-second ticks. The time can be
//   loaded or nudged (hour / minute). The display copy can be shown in 12-hour
//   format, and an optional alarm compares against a BCD time.
//
// Ports
//   clk        : system clock, rising edge
//   rst        : asynchronous active-low reset
//   run        : 1 lets the prescaler advance, 0 freezes prescaler and time
//   mode12     : 1 = 12-hour display format, 0 = 24-hour
//   load_valid : single-cycle request to load load_time
//   load_time  : BCD hh:mm:ss (24-hour) to load
//   adj_min    : single-cycle minute increment (clears seconds, no carry)
//   adj_hour   : single-cycle hour increment (minutes/seconds kept)
//   alarm_time : BCD hh:mm:ss (24-hour) alarm compare value
//   now_time   : current 24-hour BCD time
//   disp_time  : registered display time in the selected format
//   pm         : registered, 1 when the hour is 12 or later
//   sec_tick, min_carry, hour_carry, day_wrap : one-cycle event pulses
//   load_err   : one-cycle pulse when a load is rejected
//   alarm_hit  : one-cycle pulse when the time becomes equal to alarm_time
// -----------------------------------------------------------------------------
module bcd_time_counter #(
   parameter int unsigned TICK_DIV = 100000000,
   parameter bit          ALARM_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        run,
   input  logic        mode12,
   input  logic        load_valid,
   input  logic [23:0] load_time,
   input  logic        adj_min,
   input  logic        adj_hour,
   input  logic [23:0] alarm_time,
   output logic [23:0] now_time,
   output logic [23:0] disp_time,
   output logic        pm,
   output logic        sec_tick,
   output logic        min_carry,
   output logic        hour_carry,
   output logic        day_wrap,
   output logic        load_err,
   output logic        alarm_hit
);

   localparam int unsigned      DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   // A time is legal when every digit is BCD and h <= 23, m <= 59, s <= 59.
   function automatic logic legal_time(input logic [23:0] t);
      logic hour_ok, min_ok, sec_ok;
      hour_ok = (t[19:16] <= 4'd9) &&
                ((t[23:20] <= 4'd1) || ((t[23:20] == 4'd2) && (t[19:16] <= 4'd3)));
      min_ok  = (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9);
      sec_ok  = (t[7:4]   <= 4'd5) && (t[3:0]  <= 4'd9);
      return hour_ok && min_ok && sec_ok;
   endfunction

   function automatic logic [7:0] inc_mod60(input logic [7:0] v);
      if (v[3:0] != 4'd9)      return {v[7:4], v[3:0] + 4'd1};
      else if (v[7:4] != 4'd5) return {v[7:4] + 4'd1, 4'd0};
      else                     return 8'h00;
   endfunction

   function automatic logic [7:0] inc_mod24(input logic [7:0] v);
      if (v == 8'h23)          return 8'h00;
      else if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      else                     return {v[7:4], v[3:0] + 4'd1};
   endfunction

   logic [DIV_W-1:0] div_q, div_d;
   logic [23:0]      now_q, now_d;
   logic [23:0]      disp_q, disp_d;
   logic             pm_q, pm_d;
   logic             sec_tick_q, sec_tick_d;
   logic             min_carry_q, min_carry_d;
   logic             hour_carry_q, hour_carry_d;
   logic             day_wrap_q, day_wrap_d;
   logic             load_err_q, load_err_d;
   logic             upd_q, upd_d;         // now_time was written by the last edge

   logic tick;
   logic sec_wrap, min_wrap, hour_wrap;

   assign tick      = run && (div_q == DIV_LAST);
   assign sec_wrap  = (now_q[7:0] == 8'h59);
   assign min_wrap  = sec_wrap && (now_q[15:8] == 8'h59);
   assign hour_wrap = min_wrap && (now_q[23:16] == 8'h23);

   // Next time / prescaler, priority load > adj_hour > adj_min > tick.
   always_comb begin
      div_d        = div_q;
      now_d        = now_q;
      sec_tick_d   = 1'b0;
      min_carry_d  = 1'b0;
      hour_carry_d = 1'b0;
      day_wrap_d   = 1'b0;
      load_err_d   = 1'b0;
      upd_d        = 1'b0;

      if (run) div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);

      if (load_valid) begin
         if (legal_time(load_time)) begin
            now_d = load_time;
            div_d = '0;
            upd_d = 1'b1;
         end else begin
            // Rejected load freezes the prescaler for this cycle.
            div_d      = div_q;
            load_err_d = 1'b1;
         end
      end else if (adj_hour) begin
         now_d[23:16] = inc_mod24(now_q[23:16]);
         upd_d        = 1'b1;
      end else if (adj_min) begin
         now_d[15:8] = inc_mod60(now_q[15:8]);
         now_d[7:0]  = 8'h00;
         upd_d       = 1'b1;
      end else if (tick) begin
         now_d[7:0] = inc_mod60(now_q[7:0]);
         if (sec_wrap) now_d[15:8]  = inc_mod60(now_q[15:8]);
         if (min_wrap) now_d[23:16] = inc_mod24(now_q[23:16]);
         sec_tick_d   = 1'b1;
         min_carry_d  = sec_wrap;
         hour_carry_d = min_wrap;
         day_wrap_d   = hour_wrap;
         upd_d        = 1'b1;
      end
   end

   // 12-hour hour conversion goes through binary to keep the mapping obvious.
   logic [4:0] hour_bin, hour12_bin;
   logic [7:0] hour12_bcd;

   always_comb begin
      hour_bin = 5'(now_q[23:20]) * 5'd10 + 5'(now_q[19:16]);
      if (hour_bin == 5'd0)       hour12_bin = 5'd12;
      else if (hour_bin > 5'd12)  hour12_bin = hour_bin - 5'd12;
      else                        hour12_bin = hour_bin;
      if (hour12_bin >= 5'd10) hour12_bcd = {4'd1, 4'(hour12_bin - 5'd10)};
      else                     hour12_bcd = {4'd0, hour12_bin[3:0]};
      disp_d = mode12 ? {hour12_bcd, now_q[15:0]} : now_q;
      pm_d   = (now_q[23:16] >= 8'h12);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q        <= '0;
         now_q        <= '0;
         disp_q       <= '0;
         pm_q         <= 1'b0;
         sec_tick_q   <= 1'b0;
         min_carry_q  <= 1'b0;
         hour_carry_q <= 1'b0;
         day_wrap_q   <= 1'b0;
         load_err_q   <= 1'b0;
         upd_q        <= 1'b0;
      end else begin
         div_q        <= div_d;
         now_q        <= now_d;
         disp_q       <= disp_d;
         pm_q         <= pm_d;
         sec_tick_q   <= sec_tick_d;
         min_carry_q  <= min_carry_d;
         hour_carry_q <= hour_carry_d;
         day_wrap_q   <= day_wrap_d;
         load_err_q   <= load_err_d;
         upd_q        <= upd_d;
      end
   end

   generate
      if (ALARM_EN) begin : g_alarm
         logic alarm_eq, alarm_eq_q, alarm_hit_q;

         assign alarm_eq = legal_time(alarm_time) && (now_q == alarm_time);

         // Fire only when a write made the time newly equal; a frozen clock
         // sitting on the alarm time does not re-trigger.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               alarm_eq_q  <= 1'b0;
               alarm_hit_q <= 1'b0;
            end else begin
               alarm_eq_q  <= alarm_eq;
               alarm_hit_q <= upd_q && alarm_eq && !alarm_eq_q;
            end
         end

         assign alarm_hit = alarm_hit_q;
      end else begin : g_no_alarm
         assign alarm_hit = 1'b0;
      end
   endgenerate

   assign now_time   = now_q;
   assign disp_time  = disp_q;
   assign pm         = pm_q;
   assign sec_tick   = sec_tick_q;
   assign min_carry  = min_carry_q;
   assign hour_carry = hour_carry_q;
   assign day_wrap   = day_wrap_q;
   assign load_err   = load_err_q;

endmodule

// File: tb/tb_bcd_time_counter.sv
module tb_bcd_time_counter;

   localparam int TD  = 4;
   localparam int DAY = 86400;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic        mode12;
   logic        load_valid;
   logic [23:0] load_time;
   logic        adj_min;
   logic        adj_hour;
   logic [23:0] alarm_time;
   logic [23:0] now_time;
   logic [23:0] disp_time;
   logic        pm;
   logic        sec_tick;
   logic        min_carry;
   logic        hour_carry;
   logic        day_wrap;
   logic        load_err;
   logic        alarm_hit;

   bcd_time_counter #(.TICK_DIV(TD), .ALARM_EN(1'b1)) dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .mode12     (mode12),
      .load_valid (load_valid),
      .load_time  (load_time),
      .adj_min    (adj_min),
      .adj_hour   (adj_hour),
      .alarm_time (alarm_time),
      .now_time   (now_time),
      .disp_time  (disp_time),
      .pm         (pm),
      .sec_tick   (sec_tick),
      .min_carry  (min_carry),
      .hour_carry (hour_carry),
      .day_wrap   (day_wrap),
      .load_err   (load_err),
      .alarm_hit  (alarm_hit)
   );

   always #5 clk = ~clk;

   int comp_cnt = 0;
   int err_cnt  = 0;

   // Reference model: time as seconds of the day, prescaler as an integer.
   int          m_secs;
   int          m_div;
   bit          m_changed;
   bit          m_eq_before;
   logic [23:0] e_disp;
   bit          e_pm, e_tick, e_minc, e_hourc, e_dayw, e_lerr, e_hit;

   function automatic int bcd_to_secs(input logic [23:0] t);
      int d[6];
      int h, m, s;
      for (int i = 0; i < 6; i++) begin
         d[i] = int'(t[i*4 +: 4]);
         if (d[i] > 9) return -1;
      end
      h = d[5] * 10 + d[4];
      m = d[3] * 10 + d[2];
      s = d[1] * 10 + d[0];
      if (h > 23 || m > 59 || s > 59) return -1;
      return h * 3600 + m * 60 + s;
   endfunction

   function automatic logic [23:0] secs_to_bcd(input int s, input bit m12);
      int h, mi, se;
      h  = s / 3600;
      mi = (s / 60) % 60;
      se = s % 60;
      if (m12) begin
         if (h == 0)      h = 12;
         else if (h > 12) h = h - 12;
      end
      return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(se / 10), 4'(se % 10)};
   endfunction

   task automatic model_reset();
      m_secs = 0; m_div = 0; m_changed = 0; m_eq_before = 0;
      e_disp = '0; e_pm = 0; e_tick = 0; e_minc = 0; e_hourc = 0;
      e_dayw = 0; e_lerr = 0; e_hit = 0;
   endtask

   task automatic model_edge();
      int  old, a, ld, h, mi;
      bit  changed;
      a       = bcd_to_secs(alarm_time);
      e_disp  = secs_to_bcd(m_secs, mode12);
      e_pm    = (m_secs >= 12 * 3600);
      e_hit   = m_changed && (a >= 0) && (m_secs == a) && !m_eq_before;
      e_tick  = 0; e_minc = 0; e_hourc = 0; e_dayw = 0; e_lerr = 0;
      old     = m_secs;
      changed = 0;
      if (load_valid) begin
         ld = bcd_to_secs(load_time);
         if (ld >= 0) begin
            m_secs = ld; m_div = 0; changed = 1;
         end else begin
            e_lerr = 1;
         end
      end else begin
         if (run) begin
            if (m_div == TD - 1 && !adj_hour && !adj_min) begin
               e_tick  = 1;
               e_minc  = (old % 60) == 59;
               e_hourc = (old % 3600) == 3599;
               e_dayw  = (old == DAY - 1);
               m_secs  = (old + 1) % DAY;
               changed = 1;
            end
            m_div = (m_div + 1) % TD;
         end
         if (adj_hour) begin
            h       = (old / 3600 + 1) % 24;
            m_secs  = h * 3600 + old % 3600;
            changed = 1;
         end else if (adj_min) begin
            mi      = ((old / 60) % 60 + 1) % 60;
            m_secs  = (old / 3600) * 3600 + mi * 60;
            changed = 1;
         end
      end
      m_eq_before = (old == a);
      m_changed   = changed;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      comp_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("now_time",   32'(now_time),   32'(secs_to_bcd(m_secs, 1'b0)));
      chk("disp_time",  32'(disp_time),  32'(e_disp));
      chk("pm",         32'(pm),         32'(e_pm));
      chk("sec_tick",   32'(sec_tick),   32'(e_tick));
      chk("min_carry",  32'(min_carry),  32'(e_minc));
      chk("hour_carry", 32'(hour_carry), 32'(e_hourc));
      chk("day_wrap",   32'(day_wrap),   32'(e_dayw));
      chk("load_err",   32'(load_err),   32'(e_lerr));
      chk("alarm_hit",  32'(alarm_hit),  32'(e_hit));
   endtask

   // One clock: model and DUT take the same edge, compare 1 time unit later,
   // then drop the single-cycle requests.
   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
      load_valid = 1'b0;
      adj_min    = 1'b0;
      adj_hour   = 1'b0;
   endtask

   task automatic do_load(input logic [23:0] t);
      load_time  = t;
      load_valid = 1'b1;
      step();
   endtask

   task automatic check_reset_zero(input string tag);
      chk({tag, "_now"},  32'(now_time),  32'h0);
      chk({tag, "_disp"}, 32'(disp_time), 32'h0);
      chk({tag, "_pm"},   32'(pm),        32'h0);
      chk({tag, "_pulses"},
          32'({sec_tick, min_carry, hour_carry, day_wrap, load_err, alarm_hit}), 32'h0);
   endtask

   initial begin
      int hits;
      int r;

      rst = 1'b0; run = 1'b0; mode12 = 1'b1; load_valid = 1'b0; load_time = '0;
      adj_min = 1'b0; adj_hour = 1'b0; alarm_time = 24'h995959;
      model_reset();
      #12;
      check_reset_zero("reset");
      rst = 1'b1;
      mode12 = 1'b0;
      step();

      // Day rollover with all carries together.
      run = 1'b1;
      do_load(24'h235958);
      chk("load_235958", 32'(now_time), 32'h235958);
      repeat (TD) step();
      chk("tick_235959", 32'(now_time), 32'h235959);
      chk("tick_pulse", 32'(sec_tick), 32'h1);
      repeat (TD) step();
      chk("wrap_now", 32'(now_time), 32'h000000);
      chk("wrap_carries", 32'({min_carry, hour_carry, day_wrap}), 32'h7);

      // Illegal loads rejected, time kept.
      do_load(24'h240000);
      chk("rej_24h_err", 32'(load_err), 32'h1);
      chk("rej_24h_now", 32'(now_time), 32'h000000);
      do_load(24'h126A00);
      chk("rej_6A_err", 32'(load_err), 32'h1);
      chk("rej_6A_now", 32'(now_time), 32'h000000);
      repeat (6) step();

      // 12-hour display.
      run = 1'b0; mode12 = 1'b1;
      do_load(24'h003000); step();
      chk("m12_0030_disp", 32'(disp_time), 32'h123000);
      chk("m12_0030_pm", 32'(pm), 32'h0);
      do_load(24'h130509); step();
      chk("m12_1305_disp", 32'(disp_time), 32'h010509);
      chk("m12_1305_pm", 32'(pm), 32'h1);
      do_load(24'h120000); step();
      chk("m12_1200_disp", 32'(disp_time), 32'h120000);
      chk("m12_1200_pm", 32'(pm), 32'h1);
      mode12 = 1'b0; step();
      chk("m24_1200_disp", 32'(disp_time), 32'h120000);

      // Manual adjust with run=0.
      do_load(24'h105930);
      adj_min = 1'b1; step();
      chk("adjmin_now", 32'(now_time), 32'h100000);
      chk("adjmin_carry", 32'({min_carry, hour_carry}), 32'h0);
      do_load(24'h231520);
      adj_hour = 1'b1; step();
      chk("adjhr_now", 32'(now_time), 32'h001520);
      chk("adjhr_daywrap", 32'(day_wrap), 32'h0);

      // Alarm fires once, not again while the time is frozen on it.
      alarm_time = 24'h070000;
      run = 1'b1;
      do_load(24'h065959);
      repeat (TD) step();
      chk("alarm_now", 32'(now_time), 32'h070000);
      run = 1'b0;
      hits = 0;
      repeat (12) begin
         step();
         if (alarm_hit) hits++;
      end
      chk("alarm_count", 32'(hits), 32'd1);

      // Load on the terminal count wins; prescaler restarts from 0.
      run = 1'b1;
      do_load(24'h010203);
      repeat (TD - 1) step();
      do_load(24'h050607);
      chk("tc_load_now", 32'(now_time), 32'h050607);
      chk("tc_load_tick", 32'(sec_tick), 32'h0);
      repeat (TD - 1) step();
      chk("tc_load_notick", 32'(now_time), 32'h050607);
      step();
      chk("tc_load_next", 32'(now_time), 32'h050608);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         run    = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode12 = ~mode12;
         if ($urandom_range(0, 29) == 0)
            alarm_time = secs_to_bcd((m_secs + int'($urandom_range(1, 3))) % DAY, 1'b0);
         r = int'($urandom_range(0, 39));
         if (r == 0) begin
            load_valid = 1'b1;
            load_time  = ($urandom_range(0, 3) == 0) ? 24'($urandom)
                         : secs_to_bcd(int'($urandom_range(0, DAY - 1)), 1'b0);
         end else if (r == 1) begin
            load_valid = 1'b1;
            load_time  = secs_to_bcd(DAY - 1 - int'($urandom_range(0, 2)), 1'b0);
         end
         adj_hour = ($urandom_range(0, 24) == 0);
         adj_min  = ($urandom_range(0, 24) == 0);
         step();
      end

      // Asynchronous reset mid-count clears everything at once.
      run = 1'b1;
      do_load(24'h215959);
      step();
      #2;
      rst = 1'b0;
      #1;
      check_reset_zero("async_rst");
      model_reset();
      #1;
      rst = 1'b1;
      run = 1'b1;
      repeat (TD - 1) step();
      chk("post_rst_notick", 32'(sec_tick), 32'h0);
      step();
      chk("post_rst_tick", 32'(sec_tick), 32'h1);
      chk("post_rst_now", 32'(now_time), 32'h000001);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", comp_cnt, err_cnt);
      $finish;
   end

endmodule
